// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle Moore main control with ALU decode and memory wait-states; in clk/reset/Op/Funct/Rd/MemReady, out datapath enables, mux selects, ALUControl/FlagW/NoWrite, sticky Undef, debug State
module mc_control_fsm #(
  parameter int ALUCTRL_W = 3,
  parameter bit EXT_OPS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic                 MemReady,
  output logic                 IRWrite,
  output logic                 NextPC,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 Branch,
  output logic                 PCS,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           FlagW,
  output logic                 NoWrite,
  output logic                 Undef,
  output logic [3:0]           State
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    UNDEF  = 4'd10
  } state_t;
  state_t     state_q, state_d;
  logic       undef_q, undef_d;
  logic       dec_ok, dec_nw, alu_on, en;
  logic [2:0] dec_alu;
  logic [1:0] dec_fw;
  always_comb begin
    dec_ok  = 1'b1;
    dec_alu = 3'b000;
    dec_fw  = {2{Funct[0]}};
    dec_nw  = 1'b0;
    case (Funct[4:1])
      4'b0100: dec_alu = 3'b000;
      4'b0010: dec_alu = 3'b001;
      4'b0000: begin dec_alu = 3'b010; dec_fw = {Funct[0], 1'b0}; end
      4'b1100: begin dec_alu = 3'b011; dec_fw = {Funct[0], 1'b0}; end
      4'b0001: begin dec_alu = 3'b100; dec_fw = {Funct[0], 1'b0}; dec_ok = EXT_OPS; end
      4'b1101: begin dec_alu = 3'b101; dec_fw = {Funct[0], 1'b0}; dec_ok = EXT_OPS; end
      4'b1010: begin dec_alu = 3'b001; dec_fw = 2'b11; dec_nw = 1'b1; dec_ok = EXT_OPS; end
      4'b1011: begin dec_alu = 3'b000; dec_fw = 2'b11; dec_nw = 1'b1; dec_ok = EXT_OPS; end
      4'b1000: begin dec_alu = 3'b010; dec_fw = 2'b10; dec_nw = 1'b1; dec_ok = EXT_OPS; end
      default: dec_ok = 1'b0;
    endcase
    if (!dec_ok) begin
      dec_alu = 3'b000;
      dec_fw  = 2'b00;
      dec_nw  = 1'b1;
    end
  end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:        state_d = MemReady ? DECODE : FETCH;
      DECODE:       state_d = (Op == 2'b00) ? (Funct[5] ? EXECI : EXECR) :
                              (Op == 2'b01) ? MEMADR :
                              (Op == 2'b10) ? BRANCH : UNDEF;
      MEMADR:       state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:        state_d = MemReady ? MEMWB : MEMRD;
      MEMWR:        state_d = MemReady ? FETCH : MEMWR;
      EXECR, EXECI: state_d = dec_ok ? ALUWB : UNDEF;
      UNDEF:        state_d = UNDEF;
      default:      state_d = FETCH;
    endcase
    undef_d = undef_q | (state_d == UNDEF);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      undef_q <= 1'b0;
    end else begin
      state_q <= state_d;
      undef_q <= undef_d;
    end
  end
  // enables are gated by reset directly so an in-flight write drops without waiting for an edge
  assign en         = ~reset;
  assign alu_on     = state_q inside {EXECR, EXECI, ALUWB};
  assign ALUControl = alu_on ? ALUCTRL_W'(dec_alu) : '0;
  assign FlagW      = alu_on ? dec_fw : 2'b00;
  assign NoWrite    = alu_on & dec_nw;
  assign IRWrite    = en & (state_q == FETCH) & MemReady;
  assign NextPC     = IRWrite;
  assign RegWrite   = en & ((state_q == MEMWB) | ((state_q == ALUWB) & ~dec_nw));
  assign PCS        = RegWrite & (Rd == 4'd15);
  assign MemWrite   = en & (state_q == MEMWR);
  assign Branch     = en & (state_q == BRANCH);
  assign AdrSrc     = state_q inside {MEMRD, MEMWR};
  assign ALUSrcA    = state_q inside {FETCH, DECODE};
  assign ALUSrcB    = (state_q inside {FETCH, DECODE}) ? 2'b10 :
                      (state_q inside {MEMADR, EXECI, BRANCH}) ? 2'b01 : 2'b00;
  assign ResultSrc  = (state_q inside {FETCH, DECODE, BRANCH}) ? 2'b10 :
                      (state_q == MEMWB) ? 2'b01 : 2'b00;
  assign Undef      = undef_q;
  assign State      = state_q;
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multicycle successor to the single-cycle ALU decoder. Combines a Moore main-control FSM with a parametrised, extended ALU decoder, and adds memory wait-state handshaking. It sits in the controller between the instruction register (Op, Funct, Rd) and the datapath muxes and enables. Conditional gating of write enables by the condition unit stays external.

Parameters:
ALUCTRL_W, 3, ALUControl width; minimum 3, upper bits zero-filled.
EXT_OPS, 1, 1 enables EOR/MOV/CMP/CMN/TST decode; 0 means only ADD/SUB/AND/ORR are valid.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; forces state FETCH
Op  in  2  instruction [27:26]
Funct  in  6  instruction [25:20]; [5]=I, [4:1]=cmd, [0]=S/L
Rd  in  4  destination register
MemReady  in  1  memory completes access this cycle
IRWrite, NextPC, RegWrite, MemWrite, Branch, PCS  out  1 each  enables
AdrSrc, ALUSrcA  out  1 each  mux selects
ALUSrcB, ResultSrc  out  2 each  mux selects
ALUControl  out  ALUCTRL_W  ALU operation
FlagW  out  2  [1]=NZ write, [0]=CV write
NoWrite  out  1  suppress register write
Undef  out  1  sticky illegal-instruction flag
State  out  4  current state, debug

Behaviour:
- Reset (async): State=FETCH(0); Undef=0. While reset is high, RegWrite, MemWrite, IRWrite, NextPC, Branch and PCS are all 0.
- Outputs are Moore outputs of State. The ALU-decode fields also depend combinationally on Funct. Any control output not listed for a state = 0.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, UNDEF 10. Encodings 11–15 go to FETCH on the next edge.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state by Op:
  - Op=00: EXECI if Funct[5]=1, else EXECR.
  - Op=01: MEMADR.
  - Op=10: BRANCH.
  - Op=11: UNDEF.
- MEMADR: ALUSrcA=0, ALUSrcB=01. Goes to MEMRD if Funct[0]=1, else MEMWR.
- MEMRD: AdrSrc=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, PCS=(Rd==15). Goes to FETCH.
- MEMWR: AdrSrc=1, MemWrite=1, held continuously while waiting. Goes to FETCH in the cycle MemReady=1.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALU-decode active. Goes to ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALU-decode active. Goes to ALUWB.
- ALUWB: ResultSrc=00, ALU-decode active. RegWrite=~NoWrite; PCS=(Rd==15)&~NoWrite. Goes to FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1. Goes to FETCH.
- UNDEF: all enables 0. Undef is set and remains 1 until reset. The FSM stays in UNDEF.
- ALU-decode (active in EXECR, EXECI, ALUWB only; elsewhere ALUControl=0 (ADD), FlagW=00, NoWrite=0):
  - ADD 0100 → 000; arithmetic.
  - SUB 0010 → 001; arithmetic.
  - AND 0000 → 010; logical.
  - ORR 1100 → 011; logical.
  - EOR 0001 → 100; logical; EXT_OPS only.
  - MOV 1101 → 101 (pass B); logical; EXT_OPS only.
  - CMP 1010 → 001, NoWrite=1, FlagW=11; EXT_OPS only.
  - CMN 1011 → 000, NoWrite=1, FlagW=11; EXT_OPS only.
  - TST 1000 → 010, NoWrite=1, FlagW=10; EXT_OPS only.
  - Arithmetic: FlagW = S ? 11 : 00. Logical: FlagW = S ? 10 : 00.
- Unsupported cmd (or an EXT_OPS-only cmd when EXT_OPS=0): the decoder drives ALUControl=000, FlagW=00, NoWrite=1; in the cycle the FSM is in EXECR/EXECI, it transitions to UNDEF instead of ALUWB. No latch inferred; every path assigns every output.
- Funct, Op and Rd must be stable after FETCH completes; the block does not register them.
- Reset asserted mid-access (e.g. in MEMWR) removes MemWrite immediately, without waiting for a clock edge.

Test Plan:
- ADD register, S=1: Op=00, Funct=001001 (I=0, cmd=0100, S=1), MemReady=1 → states 0,1,6,8,0; in ALUWB RegWrite=1, ALUControl=000, FlagW=11.
- CMP immediate: Funct=110101 (I=1, cmd=1010, S=1) → path 0,1,7,8; in ALUWB NoWrite=1, RegWrite=0, ALUControl=001, FlagW=11.
- LDR with wait states: Op=01, Funct[0]=1; MemReady=0 for 3 cycles in FETCH and 2 in MEMRD → IRWrite pulses once; MEMRD lasts 3 cycles; MEMWB RegWrite=1; with Rd=15, PCS=1.
- STR reset mid-wait: in MEMWR with MemReady=0, assert reset between edges → MemWrite drops to 0 immediately; after release, State=0.
- EOR with EXT_OPS=0: cmd=0001 → EXECR then UNDEF(10); Undef=1 and stays set across 5 further cycles with no enables asserted; with EXT_OPS=1 the same stimulus gives ALUControl=100, FlagW=10 when S=1.
- Branch and Op=11: Op=10 → BRANCH with Branch=1, ALUSrcB=01, then FETCH; Op=11 → UNDEF.
